// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic-computing blocks: FSM state
// encodings and the LFSR feedback tap table.
package stoch_pkg;

  // Regenerator FSM: ACQ = first window after reset/restart, RUN = live output
  localparam logic [0:0] ST_ACQ = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;

  // Fibonacci tap masks for maximal-length sequences, widths 3..8.
  // Bit k set means register bit k feeds the XOR; the result shifts into bit 0.
  function automatic logic [7:0] lfsr_taps(input int w);
    logic [7:0] m;
    case (w)
      3:       m = 8'b0000_0110;  // x^3+x^2+1
      4:       m = 8'b0000_1100;  // x^4+x^3+1
      5:       m = 8'b0001_0100;  // x^5+x^3+1
      6:       m = 8'b0011_0000;  // x^6+x^5+1
      7:       m = 8'b0110_0000;  // x^7+x^6+1
      8:       m = 8'b1011_1000;  // x^8+x^6+x^5+x^4+1
      default: m = 8'b0000_1100;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Maximal-length Fibonacci LFSR with clock enable. Never holds zero: a zero
// seed is replaced by 1 so the register cannot lock up.
module lfsr_gen
  import stoch_pkg::*;
#(
  parameter int             W    = 4,
  parameter logic [W-1:0]   SEED = W'(1)
) (
  input  logic         CLK,
  input  logic         INITn,
  input  logic         EN,
  output logic [W-1:0] Q
);

  localparam logic [7:0]   TAPS8   = lfsr_taps(W);
  localparam logic [W-1:0] TAPS    = TAPS8[W-1:0];
  localparam logic [W-1:0] SEED_OK = (SEED == '0) ? W'(1) : SEED;

  // Shift left one step per enabled clock, feedback into the LSB
  always_ff @(posedge CLK or negedge INITn) begin
    if (!INITn)  Q <= SEED_OK;
    else if (EN) Q <= {Q[W-2:0], ^(Q & TAPS)};
  end

endmodule

// File: rtl/burst_regen.sv
// Burst-to-stochastic regenerator: counts ones over a 2^W-1 sample window and
// re-emits a randomized stream of the same density by comparing a free-running
// LFSR against the latched count.
module burst_regen
  import stoch_pkg::*;
#(
  parameter int           W    = 4,
  parameter logic [W-1:0] SEED = W'(1)
) (
  input  logic         CLK,
  input  logic         INITn,
  input  logic         EN,
  input  logic         CLR,
  input  logic         IN,
  output logic         OUT,
  output logic [W-1:0] P_EST,
  output logic         P_VALID,
  output logic         WIN_DONE
);

  // Last sample index of a window: 2^W-2
  localparam logic [W-1:0] WEND = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] wcnt;
  logic [W-1:0] ones;
  logic [W-1:0] lfsr;
  logic [0:0]   state;
  logic         win_end;

  // LFSR keeps running through CLR so successive restarts stay decorrelated
  lfsr_gen #(.W(W), .SEED(SEED)) u_lfsr (
    .CLK   (CLK),
    .INITn (INITn),
    .EN    (EN),
    .Q     (lfsr)
  );

  assign win_end = (wcnt == WEND);
  assign P_VALID = (state == ST_RUN);

  // Window sample counter and ones accumulator
  always_ff @(posedge CLK or negedge INITn) begin
    if (!INITn) begin
      wcnt <= '0;
      ones <= '0;
    end else if (EN) begin
      if (CLR || win_end) begin
        wcnt <= '0;
        ones <= '0;
      end else begin
        wcnt <= wcnt + W'(1);
        ones <= ones + W'(IN);
      end
    end
  end

  // Estimate latch, window-done pulse and ACQ->RUN transition; CLR wins over window end
  always_ff @(posedge CLK or negedge INITn) begin
    if (!INITn) begin
      P_EST    <= '0;
      WIN_DONE <= 1'b0;
      state    <= ST_ACQ;
    end else begin
      WIN_DONE <= 1'b0;
      if (EN) begin
        if (CLR) begin
          P_EST <= '0;
          state <= ST_ACQ;
        end else if (win_end) begin
          P_EST    <= ones + W'(IN);
          WIN_DONE <= 1'b1;
          state    <= ST_RUN;
        end
      end
    end
  end

  // Registered comparator; output held low until the first estimate exists
  always_ff @(posedge CLK or negedge INITn) begin
    if (!INITn)  OUT <= 1'b0;
    else if (EN) OUT <= !CLR && (state == ST_RUN) && (lfsr <= P_EST);
  end

endmodule
